hwpe_sel_sequencer: RTL and testbench

- Runtime controller for a multi-HWPE subsystem; next generation of the static-select HWPE wrapper.
- Replaces the raw `hwpe_sel` / `hwpe_en` decode with a safe switch sequence: quiesce the active HWPE, drain its outstanding TCDM and config-bus transactions, gate its clock, then ungate and select the new one.
- Sits between the cluster control registers and the HWPE clock gates, the static HCI mux and the config-bus mux.
- Adds outstanding-transaction backpressure and error reporting.

---
 rtl/hwpe_sel_sequencer_pkg.sv | 20 ++
 rtl/hwpe_sel_sequencer_if.sv | 44 ++++
 rtl/hwpe_outstanding_cnt.sv | 37 +++
 rtl/hwpe_sel_sequencer.sv | 141 ++++++++++++++
 tb/tb_hwpe_sel_sequencer.sv | 280 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/hwpe_sel_sequencer_pkg.sv
// Shared types and constants for the HWPE select sequencer.
// FSM states, error bit positions and an index-width helper.
package hwpe_sel_sequencer_pkg;

    typedef enum logic [2:0] {
        OFF,
        SWITCH,
        RUN,
        DRAIN,
        GATE
    } hwpe_seq_state_e;

    localparam int HWPE_SEQ_ERR_RANGE     = 0;
    localparam int HWPE_SEQ_ERR_UNDERFLOW = 1;

    function automatic int idx_width(int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/hwpe_sel_sequencer_if.sv
// Control/handshake bundle between cluster registers and the sequencer.
// master = cluster side, slave = sequencer.
interface hwpe_sel_sequencer_if
    import hwpe_sel_sequencer_pkg::*;
#(
    parameter int N_HWPES = 2,
    parameter int SEL_W   = 2,
    parameter int SW      = idx_width(N_HWPES)
);
    logic               hwpe_en_i;
    logic [SEL_W-1:0]   hwpe_sel_i;
    logic               clear_i;
    logic [N_HWPES-1:0] busy_i;
    logic               tcdm_req_i;
    logic               tcdm_gnt_i;
    logic               tcdm_r_valid_i;
    logic               cfg_req_i;
    logic               cfg_gnt_i;
    logic               cfg_r_valid_i;
    logic [SW-1:0]      sel_o;
    logic [N_HWPES-1:0] clk_en_o;
    logic               tcdm_req_mask_o;
    logic               cfg_req_mask_o;
    logic               switching_o;
    logic               busy_o;
    logic [1:0]         err_o;

    modport master (
        output hwpe_en_i, hwpe_sel_i, clear_i, busy_i,
        output tcdm_req_i, tcdm_gnt_i, tcdm_r_valid_i,
        output cfg_req_i, cfg_gnt_i, cfg_r_valid_i,
        input  sel_o, clk_en_o, tcdm_req_mask_o, cfg_req_mask_o,
        input  switching_o, busy_o, err_o
    );

    modport slave (
        input  hwpe_en_i, hwpe_sel_i, clear_i, busy_i,
        input  tcdm_req_i, tcdm_gnt_i, tcdm_r_valid_i,
        input  cfg_req_i, cfg_gnt_i, cfg_r_valid_i,
        output sel_o, clk_en_o, tcdm_req_mask_o, cfg_req_mask_o,
        output switching_o, busy_o, err_o
    );

endinterface

// File: rtl/hwpe_outstanding_cnt.sv
// Outstanding-transaction counter with saturation flag and underflow pulse.
// Saturation releases in the cycle a response arrives.
module hwpe_outstanding_cnt #(
    parameter  int MAX_OUTSTANDING = 8,
    localparam int CW              = $clog2(MAX_OUTSTANDING + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          inc_i,
    input  logic          dec_i,
    output logic [CW-1:0] count_o,
    output logic          sat_o,
    output logic          underflow_o
);

    logic [CW-1:0] count_q;
    logic          at_max;
    logic          at_zero;

    assign at_max  = (count_q == CW'(MAX_OUTSTANDING));
    assign at_zero = (count_q == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else if (inc_i && !dec_i && !at_max) begin
            count_q <= count_q + CW'(1);
        end else if (dec_i && !inc_i && !at_zero) begin
            count_q <= count_q - CW'(1);
        end
    end

    assign count_o     = count_q;
    assign sat_o       = at_max & ~dec_i;
    assign underflow_o = dec_i & ~inc_i & at_zero;

endmodule

// File: rtl/hwpe_sel_sequencer.sv
// Safe HWPE switch sequencer: quiesce, drain, gate, then ungate the new one.
// Drives clock gates, HCI/config mux select and request masks.
module hwpe_sel_sequencer
    import hwpe_sel_sequencer_pkg::*;
#(
    parameter int N_HWPES         = 2,
    parameter int SEL_W           = 2,
    parameter int MAX_OUTSTANDING = 8,
    parameter int CG_SETTLE       = 2
) (
    input logic                 clk,
    input logic                 rst_n,
    hwpe_sel_sequencer_if.slave bus
);

    localparam int SW  = idx_width(N_HWPES);
    localparam int STW = (CG_SETTLE > 1) ? $clog2(CG_SETTLE) : 1;
    localparam int CW  = $clog2(MAX_OUTSTANDING + 1);

    hwpe_seq_state_e state_q;
    logic [SW-1:0]   sel_q;
    logic [SW-1:0]   target_q;
    logic [STW-1:0]  settle_q;
    logic [1:0]      err_q;
    logic [1:0]      err_n;

    logic [CW-1:0] tcdm_cnt;
    logic [CW-1:0] cfg_cnt;
    logic          tcdm_sat;
    logic          cfg_sat;
    logic          tcdm_uf;
    logic          cfg_uf;

    logic          sel_ok;
    logic [SW-1:0] sel_in;
    logic          range_err;
    logic          drained;

    hwpe_outstanding_cnt #(
        .MAX_OUTSTANDING(MAX_OUTSTANDING)
    ) u_tcdm_cnt (
        .clk        (clk),
        .rst_n      (rst_n),
        .inc_i      (bus.tcdm_req_i & bus.tcdm_gnt_i),
        .dec_i      (bus.tcdm_r_valid_i),
        .count_o    (tcdm_cnt),
        .sat_o      (tcdm_sat),
        .underflow_o(tcdm_uf)
    );

    hwpe_outstanding_cnt #(
        .MAX_OUTSTANDING(MAX_OUTSTANDING)
    ) u_cfg_cnt (
        .clk        (clk),
        .rst_n      (rst_n),
        .inc_i      (bus.cfg_req_i & bus.cfg_gnt_i),
        .dec_i      (bus.cfg_r_valid_i),
        .count_o    (cfg_cnt),
        .sat_o      (cfg_sat),
        .underflow_o(cfg_uf)
    );

    assign sel_ok    = int'(bus.hwpe_sel_i) < N_HWPES;
    assign sel_in    = bus.hwpe_sel_i[SW-1:0];
    assign range_err = (state_q == OFF || state_q == RUN) && !sel_ok;
    assign drained   = (tcdm_cnt == '0) && (cfg_cnt == '0)
                       && !bus.busy_i[sel_q];

    // A clear and a new error in the same cycle keeps the new error.
    always_comb begin
        err_n = bus.clear_i ? 2'b00 : err_q;
        if (range_err) err_n[HWPE_SEQ_ERR_RANGE] = 1'b1;
        if (tcdm_uf || cfg_uf) err_n[HWPE_SEQ_ERR_UNDERFLOW] = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= OFF;
            sel_q    <= '0;
            target_q <= '0;
            settle_q <= '0;
            err_q    <= '0;
        end else begin
            err_q <= err_n;
            unique case (state_q)
                OFF: begin
                    if (bus.hwpe_en_i && sel_ok) begin
                        target_q <= sel_in;
                        sel_q    <= sel_in;
                        settle_q <= STW'(CG_SETTLE - 1);
                        state_q  <= SWITCH;
                    end
                end
                SWITCH: begin
                    if (settle_q == '0) state_q <= RUN;
                    else settle_q <= settle_q - STW'(1);
                end
                RUN: begin
                    if (!bus.hwpe_en_i || (sel_ok && sel_in != sel_q)) begin
                        // Keep a usable target if disabling with a bad select.
                        target_q <= sel_ok ? sel_in : sel_q;
                        state_q  <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (drained) begin
                        settle_q <= STW'(CG_SETTLE - 1);
                        state_q  <= GATE;
                    end
                end
                GATE: begin
                    if (settle_q != '0) begin
                        settle_q <= settle_q - STW'(1);
                    end else if (!bus.hwpe_en_i) begin
                        state_q <= OFF;
                    end else begin
                        sel_q    <= target_q;
                        settle_q <= STW'(CG_SETTLE - 1);
                        state_q  <= SWITCH;
                    end
                end
                default: state_q <= OFF;
            endcase
        end
    end

    always_comb begin
        bus.clk_en_o = '0;
        if (state_q == SWITCH || state_q == RUN || state_q == DRAIN)
            bus.clk_en_o[sel_q] = 1'b1;
    end

    assign bus.sel_o           = sel_q;
    assign bus.tcdm_req_mask_o = (state_q == RUN) && !tcdm_sat;
    assign bus.cfg_req_mask_o  = (state_q == RUN) && !cfg_sat;
    assign bus.switching_o     = (state_q == SWITCH) || (state_q == DRAIN)
                                 || (state_q == GATE);
    assign bus.busy_o          = bus.busy_i[sel_q] | bus.switching_o;
    assign bus.err_o           = err_q;

endmodule

// File: tb/tb_hwpe_sel_sequencer.sv
// Directed and randomized checks for hwpe_sel_sequencer.
module tb_hwpe_sel_sequencer;

    localparam int MAXO = 8;

    logic clk;
    logic rst_n;
    int   tests;
    int   fails;

    hwpe_sel_sequencer_if #(.N_HWPES(2), .SEL_W(2)) bus ();

    hwpe_sel_sequencer #(
        .N_HWPES        (2),
        .SEL_W          (2),
        .MAX_OUTSTANDING(MAXO),
        .CG_SETTLE      (2)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_all(string tag, int sel, int clk_en, int tm, int cm,
                           int sw, int bsy, int err);
        chk({tag, ".sel"}, 32'(bus.sel_o), 32'(sel));
        chk({tag, ".clk_en"}, 32'(bus.clk_en_o), 32'(clk_en));
        chk({tag, ".tmask"}, 32'(bus.tcdm_req_mask_o), 32'(tm));
        chk({tag, ".cmask"}, 32'(bus.cfg_req_mask_o), 32'(cm));
        chk({tag, ".switching"}, 32'(bus.switching_o), 32'(sw));
        chk({tag, ".busy"}, 32'(bus.busy_o), 32'(bsy));
        chk({tag, ".err"}, 32'(bus.err_o), 32'(err));
    endtask

    task automatic idle_inputs();
        bus.tcdm_req_i     = 1'b0;
        bus.tcdm_gnt_i     = 1'b0;
        bus.tcdm_r_valid_i = 1'b0;
        bus.cfg_req_i      = 1'b0;
        bus.cfg_gnt_i      = 1'b0;
        bus.cfg_r_valid_i  = 1'b0;
        bus.clear_i        = 1'b0;
    endtask

    initial begin
        int tcnt;
        int ccnt;
        logic tr, tg, trv, cr, cg, crv;
        tests = 0;
        fails = 0;
        rst_n = 1'b0;
        idle_inputs();
        bus.hwpe_en_i  = 1'b0;
        bus.hwpe_sel_i = 2'd0;
        bus.busy_i     = 2'b00;
        #2;
        chk_all("reset", 0, 0, 0, 0, 0, 0, 0);
        tick();
        rst_n = 1'b1;
        tick();
        chk_all("off_idle", 0, 0, 0, 0, 0, 0, 0);

        // Enable from OFF onto HWPE 1
        bus.hwpe_en_i  = 1'b1;
        bus.hwpe_sel_i = 2'd1;
        tick();
        chk_all("en_c1", 1, 2'b10, 0, 0, 1, 1, 0);
        tick();
        chk_all("en_c2", 1, 2'b10, 0, 0, 1, 1, 0);
        tick();
        chk_all("en_c3", 1, 2'b10, 1, 1, 0, 0, 0);

        // Idle switch to HWPE 0
        bus.hwpe_sel_i = 2'd0;
        tick();
        chk_all("sw0_drain", 1, 2'b10, 0, 0, 1, 1, 0);
        tick();
        chk_all("sw0_gate1", 1, 2'b00, 0, 0, 1, 1, 0);
        tick();
        chk_all("sw0_gate2", 1, 2'b00, 0, 0, 1, 1, 0);
        tick();
        chk_all("sw0_switch1", 0, 2'b01, 0, 0, 1, 1, 0);
        tick();
        tick();
        chk_all("sw0_run", 0, 2'b01, 1, 1, 0, 0, 0);

        // Switch with three TCDM reads in flight
        bus.busy_i     = 2'b01;
        bus.tcdm_req_i = 1'b1;
        bus.tcdm_gnt_i = 1'b1;
        repeat (3) tick();
        bus.tcdm_req_i = 1'b0;
        bus.tcdm_gnt_i = 1'b0;
        bus.hwpe_sel_i = 2'd1;
        tick();
        chk_all("inflight_drain", 0, 2'b01, 0, 0, 1, 1, 0);
        for (int k = 0; k < 3; k++) begin
            bus.tcdm_r_valid_i = 1'b1;
            tick();
            bus.tcdm_r_valid_i = 1'b0;
            tick();
            chk("inflight_hold", 32'(bus.clk_en_o), 32'(2'b01));
        end
        bus.busy_i = 2'b00;
        tick();
        chk_all("inflight_gate1", 0, 2'b00, 0, 0, 1, 1, 0);
        tick();
        chk_all("inflight_gate2", 0, 2'b00, 0, 0, 1, 1, 0);
        tick();
        chk_all("inflight_switch", 1, 2'b10, 0, 0, 1, 1, 0);
        tick();
        tick();
        chk_all("inflight_run", 1, 2'b10, 1, 1, 0, 0, 0);

        // Saturation on the TCDM counter
        bus.tcdm_req_i = 1'b1;
        bus.tcdm_gnt_i = 1'b1;
        repeat (MAXO - 1) tick();
        chk("sat_below", 32'(bus.tcdm_req_mask_o), 32'd1);
        tick();
        chk("sat_full", 32'(bus.tcdm_req_mask_o), 32'd0);
        chk("sat_cfg_unaff", 32'(bus.cfg_req_mask_o), 32'd1);
        bus.tcdm_req_i     = 1'b0;
        bus.tcdm_gnt_i     = 1'b0;
        bus.tcdm_r_valid_i = 1'b1;
        #1;
        chk("sat_release", 32'(bus.tcdm_req_mask_o), 32'd1);
        tick();
        bus.tcdm_req_i = 1'b1;
        bus.tcdm_gnt_i = 1'b1;
        tick();
        chk("sat_incdec", 32'(bus.tcdm_req_mask_o), 32'd1);
        bus.tcdm_r_valid_i = 1'b0;
        tick();
        chk("sat_refill", 32'(bus.tcdm_req_mask_o), 32'd0);
        bus.tcdm_req_i     = 1'b0;
        bus.tcdm_gnt_i     = 1'b0;
        bus.tcdm_r_valid_i = 1'b1;
        repeat (MAXO) tick();
        bus.tcdm_r_valid_i = 1'b0;
        #1;
        chk_all("sat_drained", 1, 2'b10, 1, 1, 0, 0, 0);

        // Random traffic on both buses against an integer occupancy model
        tcnt = 0;
        ccnt = 0;
        for (int i = 0; i < 300; i++) begin
            tr  = 1'($urandom_range(0, 1));
            tg  = (tcnt < MAXO) ? 1'($urandom_range(0, 1)) : 1'b0;
            trv = (tcnt > 0) ? 1'($urandom_range(0, 1)) : 1'b0;
            cr  = 1'($urandom_range(0, 1));
            cg  = (ccnt < MAXO) ? 1'($urandom_range(0, 1)) : 1'b0;
            crv = (ccnt > 0) ? 1'($urandom_range(0, 3) == 0) : 1'b0;
            bus.tcdm_req_i     = tr;
            bus.tcdm_gnt_i     = tg;
            bus.tcdm_r_valid_i = trv;
            bus.cfg_req_i      = cr;
            bus.cfg_gnt_i      = cg;
            bus.cfg_r_valid_i  = crv;
            bus.busy_i         = 2'($urandom_range(0, 3));
            #1;
            chk("rnd_tmask", 32'(bus.tcdm_req_mask_o),
                32'((tcnt < MAXO) || trv));
            chk("rnd_cmask", 32'(bus.cfg_req_mask_o),
                32'((ccnt < MAXO) || crv));
            chk("rnd_busy", 32'(bus.busy_o), 32'(bus.busy_i[1]));
            tick();
            tcnt += int'(tr && tg) - int'(trv);
            ccnt += int'(cr && cg) - int'(crv);
        end
        idle_inputs();
        bus.busy_i = 2'b00;
        for (int i = 0; i < 2 * MAXO && (tcnt > 0 || ccnt > 0); i++) begin
            bus.tcdm_r_valid_i = (tcnt > 0);
            bus.cfg_r_valid_i  = (ccnt > 0);
            tick();
            if (tcnt > 0) tcnt--;
            if (ccnt > 0) ccnt--;
        end
        idle_inputs();
        #1;
        chk_all("rnd_end", 1, 2'b10, 1, 1, 0, 0, 0);

        // Error paths
        bus.hwpe_sel_i = 2'd3;
        tick();
        bus.hwpe_sel_i = 2'd1;
        chk_all("err_range", 1, 2'b10, 1, 1, 0, 0, 2'b01);
        bus.tcdm_r_valid_i = 1'b1;
        tick();
        bus.tcdm_r_valid_i = 1'b0;
        chk("err_underflow", 32'(bus.err_o), 32'(2'b11));
        bus.clear_i = 1'b1;
        tick();
        chk("err_clear", 32'(bus.err_o), 32'd0);
        bus.hwpe_sel_i = 2'd2;
        tick();
        chk("err_clear_race", 32'(bus.err_o), 32'(2'b01));
        bus.hwpe_sel_i = 2'd1;
        tick();
        bus.clear_i = 1'b0;
        chk_all("err_cleared", 1, 2'b10, 1, 1, 0, 0, 0);

        // Disable with one config transaction outstanding
        bus.cfg_req_i = 1'b1;
        bus.cfg_gnt_i = 1'b1;
        tick();
        bus.cfg_req_i = 1'b0;
        bus.cfg_gnt_i = 1'b0;
        bus.hwpe_en_i = 1'b0;
        tick();
        chk_all("dis_drain", 1, 2'b10, 0, 0, 1, 1, 0);
        repeat (3) tick();
        chk_all("dis_hold", 1, 2'b10, 0, 0, 1, 1, 0);
        bus.cfg_r_valid_i = 1'b1;
        tick();
        bus.cfg_r_valid_i = 1'b0;
        tick();
        chk_all("dis_gate1", 1, 2'b00, 0, 0, 1, 1, 0);
        tick();
        chk_all("dis_gate2", 1, 2'b00, 0, 0, 1, 1, 0);
        tick();
        chk_all("dis_off", 1, 2'b00, 0, 0, 0, 0, 0);
        bus.cfg_r_valid_i = 1'b1;
        tick();
        bus.cfg_r_valid_i = 1'b0;
        chk("off_underflow", 32'(bus.err_o), 32'(2'b10));
        bus.clear_i = 1'b1;
        tick();
        bus.clear_i = 1'b0;
        chk("off_clear", 32'(bus.err_o), 32'd0);

        // Asynchronous reset in the middle of DRAIN
        bus.hwpe_en_i  = 1'b1;
        bus.hwpe_sel_i = 2'd0;
        repeat (3) tick();
        chk_all("ar_run", 0, 2'b01, 1, 1, 0, 0, 0);
        bus.tcdm_req_i = 1'b1;
        bus.tcdm_gnt_i = 1'b1;
        tick();
        bus.tcdm_req_i = 1'b0;
        bus.tcdm_gnt_i = 1'b0;
        bus.hwpe_sel_i = 2'd1;
        tick();
        chk_all("ar_drain", 0, 2'b01, 0, 0, 1, 1, 0);
        rst_n = 1'b0;
        #1;
        chk_all("ar_reset", 0, 2'b00, 0, 0, 0, 0, 0);
        #2;
        rst_n = 1'b1;
        tick();
        chk_all("ar_restart", 1, 2'b10, 0, 0, 1, 1, 0);
        repeat (2) tick();
        chk_all("ar_run2", 1, 2'b10, 1, 1, 0, 0, 0);
        bus.tcdm_r_valid_i = 1'b1;
        tick();
        bus.tcdm_r_valid_i = 1'b0;
        chk("ar_cnt_cleared", 32'(bus.err_o), 32'(2'b10));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
